// File: rtl/ab_gen.sv
// ---------------------------------------------------------------------------
// ab_gen -- address-bus generator for the 65C02 core.
//
// Each rising edge (with rdy high and reset low) applies the address command
// `mode` from the control state machine and updates three registers:
//   AB  -- the 16-bit address bus presented to memory,
//   PC  -- a holding copy of the program counter, read by the data-out mux
//          when PCH/PCL are pushed,
//   ahl -- an internal 8-bit latch of the previous data-bus byte, used as the
//          low half of a two-byte absolute address.
//
// Ports
//   clk    in   1   core clock, rising edge active
//   reset  in   1   synchronous, active-high reset; wins over rdy and mode
//   rdy    in   1   low: AB, PC and ahl all hold
//   mode   in   4   address command from the control block
//   DB     in   8   data bus read in the current cycle
//   xyz    in   8   index operand (X, Y or zero)
//   sp     in   8   current stack pointer
//   vec    in   8   low byte of the interrupt/reset vector
//   cond   in   1   branch taken (only looked at in the branch command)
//   AB     out  16  registered address bus
//   PC     out  16  registered PC holding register
// ---------------------------------------------------------------------------
module ab_gen #(
  parameter logic [15:0] RESET_AB = 16'hFFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic [3:0]  mode,
  input  logic [7:0]  DB,
  input  logic [7:0]  xyz,
  input  logic [7:0]  sp,
  input  logic [7:0]  vec,
  input  logic        cond,
  output logic [15:0] AB,
  output logic [15:0] PC
);

  // Address commands. 0110 and 1101 are unused and fall into the default
  // branch, which behaves like the hold/capture command.
  typedef enum logic [3:0] {
    MODE_HOLD       = 4'b0000,
    MODE_FROM_PC    = 4'b0001,
    MODE_ABS_IDX_PC = 4'b0010,
    MODE_ZP_IDX     = 4'b0011,
    MODE_INC_PC     = 4'b0100,
    MODE_STACK_POP  = 4'b0101,
    MODE_BRANCH     = 4'b0111,
    MODE_STACK      = 4'b1000,
    MODE_STACK_PC   = 4'b1001,
    MODE_ABS_IDX    = 4'b1010,
    MODE_STACK_SAVE = 4'b1011,
    MODE_INC        = 4'b1100,
    MODE_ABS_IDX_P1 = 4'b1110,
    MODE_VECTOR     = 4'b1111
  } mode_e;

  logic [7:0]  ahl;

  logic [15:0] ab_nxt;
  logic [15:0] pc_nxt;
  logic [7:0]  ahl_nxt;

  // Shared datapath terms, all computed from pre-edge register values.
  logic [15:0] ab_inc;      // AB + 1
  logic [15:0] abs_idx;     // {DB,AHL} + xyz, full 16-bit carry into high byte
  logic [7:0]  zp_idx;      // (DB + xyz) mod 256, no page carry
  logic [7:0]  sp_inc;      // (sp + 1) mod 256, stays on page 1
  logic [15:0] br_off;      // sign-extended displacement, or 0 when not taken
  logic [15:0] br_target;   // AB + offset + 1
  logic [15:0] vec_inc;     // {FF,vec} + 1, wraps FFFF -> 0000

  assign ab_inc    = AB + 16'd1;
  assign abs_idx   = {DB, ahl} + {8'h00, xyz};
  assign zp_idx    = DB + xyz;
  assign sp_inc    = sp + 8'd1;
  assign br_off    = cond ? {{8{DB[7]}}, DB} : 16'h0000;
  assign br_target = AB + br_off + 16'd1;
  assign vec_inc   = {8'hFF, vec} + 16'd1;

  always_comb begin
    // NOTE: every target gets a "keep" default before the case, so commands
    // that leave a register untouched cannot infer a latch.
    ab_nxt  = AB;
    pc_nxt  = PC;
    ahl_nxt = ahl;

    case (mode_e'(mode))
      MODE_HOLD: begin
        ahl_nxt = DB;
      end
      MODE_FROM_PC: begin
        ab_nxt = PC;
      end
      MODE_ABS_IDX_PC: begin
        pc_nxt  = ab_inc;
        ahl_nxt = DB;
        ab_nxt  = abs_idx;
      end
      MODE_ZP_IDX: begin
        pc_nxt  = ab_inc;
        ahl_nxt = DB;
        ab_nxt  = {8'h00, zp_idx};
      end
      MODE_INC_PC: begin
        pc_nxt  = AB;
        ahl_nxt = DB;
        ab_nxt  = ab_inc;
      end
      MODE_STACK_POP: begin
        pc_nxt  = AB;
        ahl_nxt = DB;
        ab_nxt  = {8'h01, sp_inc};
      end
      MODE_BRANCH: begin
        pc_nxt  = AB;
        ahl_nxt = DB;
        ab_nxt  = br_target;
      end
      MODE_STACK: begin
        ab_nxt = {8'h01, sp};
      end
      MODE_STACK_PC: begin
        pc_nxt  = ab_inc;
        ahl_nxt = DB;
        ab_nxt  = {8'h01, sp};
      end
      MODE_ABS_IDX: begin
        ahl_nxt = DB;
        ab_nxt  = abs_idx;
      end
      MODE_STACK_SAVE: begin
        pc_nxt = AB;
        ab_nxt = {8'h01, sp};
      end
      MODE_INC: begin
        ahl_nxt = DB;
        ab_nxt  = ab_inc;
      end
      MODE_ABS_IDX_P1: begin
        ahl_nxt = DB;
        ab_nxt  = abs_idx + 16'd1;
      end
      MODE_VECTOR: begin
        ab_nxt = vec_inc;
      end
      default: begin
        // Unused codes act as the hold/capture command.
        ahl_nxt = DB;
      end
    endcase
  end

  // Reset discards whatever command is in flight, including a pending
  // PC/AHL update in the middle of a push sequence.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the same
    // pre-edge values, independent of statement order.
    if (reset) begin
      AB  <= RESET_AB;
      PC  <= 16'h0000;
      ahl <= 8'h00;
    end else if (rdy) begin
      AB  <= ab_nxt;
      PC  <= pc_nxt;
      ahl <= ahl_nxt;
    end
  end

endmodule

// File: doc/ab_gen.md
# ab_gen

Address-bus generator for the 65C02 core. Consumes the 4-bit `mode` command from the control state machine each cycle and produces the registered 16-bit address bus `AB`. It also maintains the `PC` holding register and the `AHL` hold register, and exposes `PC` so the data-out mux can push PCH/PCL. It sits directly downstream of the control block, and upstream of memory and the data-out mux.

## Interface
Parameters:
- `RESET_AB`, 16'hFFFC, value loaded into `AB` on reset.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rdy`  in  1  when low, `AB`, `PC` and `AHL` hold.
- `mode`  in  4  address command from the control block.
- `DB`  in  8  data bus read in the current cycle.
- `xyz`  in  8  index value selected by `reg_op`: X, Y or zero.
- `sp`  in  8  current stack pointer.
- `vec`  in  8  low byte of the interrupt/reset vector.
- `cond`  in  1  branch taken; only meaningful in mode 0111.
- `AB`  out  16  registered address bus.
- `PC`  out  16  registered PC holding register.

## Operation
- State: `AB`, `PC`, `AHL` (8 bit, internal).
- Each edge with `rdy`=1 and `reset`=0 applies the row for `mode`. Format is mode: PC / AHL / next AB.
- 0000: keep / DB / keep.
- 0001: keep / keep / PC.
- 0010: AB+1 / DB / {DB,AHL}+xyz.
- 0011: AB+1 / DB / {00, (DB+xyz) mod 256}.
- 0100: AB / DB / AB+1.
- 0101: AB / DB / {01, (sp+1) mod 256}.
- 0111: AB / DB / branch target.
- 1000: keep / keep / {01,sp}.
- 1001: AB+1 / DB / {01,sp}.
- 1010: keep / DB / {DB,AHL}+xyz.
- 1011: AB / keep / {01,sp}.
- 1100: keep / DB / AB+1.
- 1110: keep / DB / {DB,AHL}+xyz+1.
- 1111: keep / keep / {FF,vec}+1.
- Unused codes 0110 and 1101 behave as 0000. They are not flagged.
- Arithmetic widths:
  - {DB,AHL}+xyz and the +1 variants are 16-bit, with carry from the low byte into the high byte. There is no extra cycle and the sum wraps mod 2^16.
  - Zero-page (0011) and stack (0101) sums are 8-bit, with the high byte forced to 00 or 01; no page carry.
  - {FF,vec}+1 is 16-bit; vec=FF gives 0000.
- Branch target (mode 0111):
  - `cond`=1: AB + sign_extend(DB) + 1, 16-bit.
  - `cond`=0: AB + 1.
  - Sign is taken from DB[7].
- The "PC" columns use the `AB` value before the edge.

## Timing
- Reset values: `AB`=RESET_AB, `PC`=16'h0000, `AHL`=8'h00.
- Reset wins over `rdy` and `mode`.
- All outputs are registered. A mode applied in cycle n drives the new `AB`/`PC` in cycle n+1.
- No combinational path exists from any input to `AB` or `PC`.
- `rdy`=0: all three registers hold, and `DB` is not captured into `AHL`.
- Reset asserted mid-sequence (e.g. during a JSR push) takes effect at the next edge, discarding pending `AHL`/`PC` updates.
- `AHL` captures the `DB` of the same cycle. A mode 0010/1010/1110 in the next cycle therefore uses that byte as the low address, combined with the new `DB` as the high byte.

## Test plan
- **Reset:** reset=1 for 2 cycles, then mode=0000 → AB=FFFC, PC=0000. Then mode=0100 → AB=FFFD, PC=FFFC.
- **Absolute indexed with page carry:** AB=1000, cycle 1 mode=0100 with DB=F0 → AHL=F0. Cycle 2 mode=0010 with DB=12, xyz=20 → AB=1310, PC=1002.
- **Zero-page wrap:** mode=0011, DB=F0, xyz=20 → AB=0010 (no carry into the high byte). Stack wrap: mode=0101, sp=FF → AB=0100.
- **Branch, taken backward:** AB=2000, mode=0111, cond=1, DB=FE → AB=1FFF, PC=2000.
  - Forward across a page: AB=20F0, DB=20 → AB=2111.
  - Not taken: AB=2000, cond=0 → AB=2001.
- **JSR/vector sequence:** AB=3002, mode=1001 with sp=FD → AB=01FD, PC=3003. Then mode=1000 → AB=01FD, PC unchanged. Then mode=1111 with vec=FE → AB=FFFF.
- **rdy stall and unused codes:**
  - rdy=0 for 3 cycles with mode=0100 and varying DB → AB, PC and AHL are unchanged. Release rdy → increment resumes from the held AB.
  - mode=0110 behaves as 0000.
